// File: rtl/fp_class_pkg.sv
// ---------------------------------------------------------------------------
// fp_class_pkg
// Shared constants for the bfloat16 operand classifier:
//   - CLS_W and the class codes ZERO/SUB/NORM/INF/QNAN/SNAN (6 and 7 unused)
//   - NUM_CLS, the number of per-class event counters
//   - default bfloat16 field widths (16 total, 8 exponent, 7 fraction)
// ---------------------------------------------------------------------------
package fp_class_pkg;

    localparam int CLS_W   = 3;
    localparam int NUM_CLS = 6;

    localparam logic [CLS_W-1:0] CLS_ZERO = 3'd0;
    localparam logic [CLS_W-1:0] CLS_SUB  = 3'd1;
    localparam logic [CLS_W-1:0] CLS_NORM = 3'd2;
    localparam logic [CLS_W-1:0] CLS_INF  = 3'd3;
    localparam logic [CLS_W-1:0] CLS_QNAN = 3'd4;
    localparam logic [CLS_W-1:0] CLS_SNAN = 3'd5;

    localparam int BF16_DATA_W = 16;
    localparam int BF16_EXP_W  = 8;
    localparam int BF16_FRAC_W = 7;

endpackage : fp_class_pkg

// File: rtl/fp_classify_lane.sv
// ---------------------------------------------------------------------------
// fp_classify_lane
// Purely combinational classifier for one floating-point operand.
// Ports:
//   op_i    operand to classify
//   ftz_i   flush-to-zero request for this operand
//   cls_o   class code (post flush-to-zero)
//   sign_o  sign bit of the operand (always reported, even for NaN/zero)
//   data_o  operand, with subnormals replaced by signed zero when ftz_i=1
// ---------------------------------------------------------------------------
module fp_classify_lane
    import fp_class_pkg::*;
#(
    parameter int DATA_WIDTH = BF16_DATA_W,
    parameter int EXP_WIDTH  = BF16_EXP_W,
    parameter int FRAC_WIDTH = BF16_FRAC_W
) (
    input  logic [DATA_WIDTH-1:0] op_i,
    input  logic                  ftz_i,
    output logic [CLS_W-1:0]      cls_o,
    output logic                  sign_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam logic [EXP_WIDTH-1:0]  EXP_ZERO  = {EXP_WIDTH{1'b0}};
    localparam logic [EXP_WIDTH-1:0]  EXP_ONES  = {EXP_WIDTH{1'b1}};
    localparam logic [FRAC_WIDTH-1:0] FRAC_ZERO = {FRAC_WIDTH{1'b0}};

    logic [EXP_WIDTH-1:0]  exp_s;
    logic [FRAC_WIDTH-1:0] frac_s;
    logic [CLS_W-1:0]      raw_cls_s;

    assign exp_s  = op_i[DATA_WIDTH-2 -: EXP_WIDTH];
    assign frac_s = op_i[FRAC_WIDTH-1:0];

    // Raw IEEE-style class from exponent/fraction fields (before flush-to-zero).
    function automatic logic [CLS_W-1:0] classify(input logic [EXP_WIDTH-1:0]  e,
                                                  input logic [FRAC_WIDTH-1:0] f);
        logic [CLS_W-1:0] c;
        if (e == EXP_ZERO) begin
            c = (f == FRAC_ZERO) ? CLS_ZERO : CLS_SUB;
        end else if (e == EXP_ONES) begin
            if (f == FRAC_ZERO) begin
                c = CLS_INF;
            end else if (f[FRAC_WIDTH-1]) begin
                c = CLS_QNAN;
            end else begin
                c = CLS_SNAN;
            end
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

    // Classify and apply flush-to-zero; only subnormals are ever rewritten.
    always_comb begin
        raw_cls_s = classify(exp_s, frac_s);
        sign_o    = op_i[DATA_WIDTH-1];
        cls_o     = raw_cls_s;
        data_o    = op_i;
        if (ftz_i && (raw_cls_s == CLS_SUB)) begin
            cls_o  = CLS_ZERO;
            data_o = {op_i[DATA_WIDTH-1], {(DATA_WIDTH-1){1'b0}}};
        end else begin
            cls_o  = raw_cls_s;
            data_o = op_i;
        end
    end

endmodule : fp_classify_lane

// File: rtl/fp_class_pipe.sv
// ---------------------------------------------------------------------------
// fp_class_pipe
// Two-stage elastic pipeline that classifies LANES packed operands per beat,
// optionally flushes subnormals to zero, and keeps saturating per-class
// event counters updated on every output handshake.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        input handshake; in_data carries LANES operands
//   ftz                      flush-to-zero request, captured with in_data
//   out_valid/out_ready      output handshake
//   out_data/out_class/out_sign  per-lane operand, class code and sign
//   cnt_clear                synchronous clear of all counters (beats a
//                            simultaneous handshake)
//   cnt_sel/cnt_value        counter read port; codes 6 and 7 read as 0
// ---------------------------------------------------------------------------
module fp_class_pipe
    import fp_class_pkg::*;
#(
    parameter int DATA_WIDTH = BF16_DATA_W,
    parameter int EXP_WIDTH  = BF16_EXP_W,
    parameter int FRAC_WIDTH = BF16_FRAC_W,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        ftz,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [LANES*CLS_W-1:0]      out_class,
    output logic [LANES-1:0]            out_sign,
    input  logic                        cnt_clear,
    input  logic [2:0]                  cnt_sel,
    output logic [CNT_WIDTH-1:0]        cnt_value
);

    localparam int BEAT_W = LANES * DATA_WIDTH;
    localparam int PC_W   = $clog2(LANES + 1);
    localparam int SUM_W  = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Stage 1: raw operands and captured ftz
    logic              s1_valid_q, s1_valid_d;
    logic [BEAT_W-1:0] s1_data_q,  s1_data_d;
    logic              s1_ftz_q,   s1_ftz_d;

    // Stage 2: classified results (drive the outputs directly)
    logic                   s2_valid_q, s2_valid_d;
    logic [BEAT_W-1:0]      out_data_q,  out_data_d;
    logic [LANES*CLS_W-1:0] out_class_q, out_class_d;
    logic [LANES-1:0]       out_sign_q,  out_sign_d;

    // Counters
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CLS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CLS];
    logic [PC_W-1:0]      pc_s  [NUM_CLS];

    // Combinational lane results and handshake terms
    logic [BEAT_W-1:0]      lane_data_s;
    logic [LANES*CLS_W-1:0] lane_class_s;
    logic [LANES-1:0]       lane_sign_s;
    logic                   s1_load_s;
    logic                   s2_load_s;
    logic                   out_fire_s;

    // Adds a lane count to a counter, clamping at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] acc,
                                                     input logic [PC_W-1:0]      inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + SUM_W'(inc);
        if (sum > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end else begin
            return sum[CNT_WIDTH-1:0];
        end
    endfunction

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            fp_classify_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .EXP_WIDTH  (EXP_WIDTH),
                .FRAC_WIDTH (FRAC_WIDTH)
            ) u_lane (
                .op_i   (s1_data_q[g*DATA_WIDTH +: DATA_WIDTH]),
                .ftz_i  (s1_ftz_q),
                .cls_o  (lane_class_s[g*CLS_W +: CLS_W]),
                .sign_o (lane_sign_s[g]),
                .data_o (lane_data_s[g*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    // S2 advances when empty or drained; S1 advances when empty or S2 takes its beat.
    // in_ready is the S1 load condition so a full pipe refills with no bubble.
    always_comb begin
        s2_load_s  = ~s2_valid_q | out_ready;
        s1_load_s  = ~s1_valid_q | s2_load_s;
        out_fire_s = s2_valid_q & out_ready;
    end

    assign in_ready = s1_load_s;

    // Next-state for stage 1: capture a beat on input handshake, else hold.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_ftz_d   = s1_ftz_q;
        if (s1_load_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_ftz_d  = ftz;
            end else begin
                s1_data_d = s1_data_q;
                s1_ftz_d  = s1_ftz_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Next-state for stage 2: take classified S1 beat when loading, hold when stalled.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        out_data_d  = out_data_q;
        out_class_d = out_class_q;
        out_sign_d  = out_sign_q;
        if (s2_load_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d  = lane_data_s;
                out_class_d = lane_class_s;
                out_sign_d  = lane_sign_s;
            end else begin
                out_data_d  = out_data_q;
                out_class_d = out_class_q;
                out_sign_d  = out_sign_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers; reset empties both stages and zeroes the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= {BEAT_W{1'b0}};
            s1_ftz_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= {BEAT_W{1'b0}};
            out_class_q <= {(LANES*CLS_W){1'b0}};
            out_sign_q  <= {LANES{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_ftz_q    <= s1_ftz_d;
            s2_valid_q  <= s2_valid_d;
            out_data_q  <= out_data_d;
            out_class_q <= out_class_d;
            out_sign_q  <= out_sign_d;
        end
    end

    // Per-class popcount over the lanes of the beat currently held in S2.
    always_comb begin
        for (int c = 0; c < NUM_CLS; c++) begin
            pc_s[c] = {PC_W{1'b0}};
            for (int l = 0; l < LANES; l++) begin
                if (out_class_q[l*CLS_W +: CLS_W] == CLS_W'(c)) begin
                    pc_s[c] = pc_s[c] + PC_W'(1);
                end else begin
                    pc_s[c] = pc_s[c];
                end
            end
        end
    end

    // Counter next-state: clear has priority over the handshake increment.
    always_comb begin
        for (int c = 0; c < NUM_CLS; c++) begin
            cnt_d[c] = cnt_q[c];
            if (cnt_clear) begin
                cnt_d[c] = {CNT_WIDTH{1'b0}};
            end else if (out_fire_s) begin
                cnt_d[c] = sat_add(cnt_q[c], pc_s[c]);
            end else begin
                cnt_d[c] = cnt_q[c];
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLS; c++) begin
                cnt_q[c] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            for (int c = 0; c < NUM_CLS; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    // Counter read mux; unused class codes read as zero.
    always_comb begin
        cnt_value = {CNT_WIDTH{1'b0}};
        case (cnt_sel)
            3'd0:    cnt_value = cnt_q[0];
            3'd1:    cnt_value = cnt_q[1];
            3'd2:    cnt_value = cnt_q[2];
            3'd3:    cnt_value = cnt_q[3];
            3'd4:    cnt_value = cnt_q[4];
            3'd5:    cnt_value = cnt_q[5];
            default: cnt_value = {CNT_WIDTH{1'b0}};
        endcase
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_class = out_class_q;
    assign out_sign  = out_sign_q;

endmodule : fp_class_pipe

// File: tb/tb_fp_class_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_class_pipe
// Scoreboard bench for fp_class_pipe (LANES=4, CNT_WIDTH=4 so saturation is
// reachable). Expected beats are predicted from the input side and queued;
// a negedge monitor pops and compares them on every output handshake, checks
// hold-stability under backpressure and tracks a reference counter model.
// ---------------------------------------------------------------------------
module tb_fp_class_pipe;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int CW    = 4;
    localparam int BW    = LANES * DW;

    typedef struct {
        logic [BW-1:0]      data;
        logic [LANES*3-1:0] cls;
        logic [LANES-1:0]   sign;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [BW-1:0]     in_data;
    logic              ftz;
    logic              out_valid;
    logic              out_ready;
    logic [BW-1:0]     out_data;
    logic [LANES*3-1:0] out_class;
    logic [LANES-1:0]  out_sign;
    logic              cnt_clear;
    logic [2:0]        cnt_sel;
    logic [CW-1:0]     cnt_value;

    int n_compared   = 0;
    int n_mismatched = 0;

    beat_t       sb_q[$];
    int          model_cnt [6];
    logic        held;
    beat_t       held_beat;

    fp_class_pipe #(
        .DATA_WIDTH (16),
        .EXP_WIDTH  (8),
        .FRAC_WIDTH (7),
        .LANES      (LANES),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ftz       (ftz),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_class (out_class),
        .out_sign  (out_sign),
        .cnt_clear (cnt_clear),
        .cnt_sel   (cnt_sel),
        .cnt_value (cnt_value)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [2:0] ref_class(input logic [15:0] op);
        logic [7:0] e;
        logic [6:0] f;
        e = op[14:7];
        f = op[6:0];
        if (e == 8'h00)      return (f == 7'd0) ? 3'd0 : 3'd1;
        else if (e == 8'hFF) return (f == 7'd0) ? 3'd3 : (f[6] ? 3'd4 : 3'd5);
        else                 return 3'd2;
    endfunction

    function automatic beat_t predict(input logic [BW-1:0] d, input logic f);
        beat_t b;
        logic [15:0] op;
        logic [2:0]  c;
        for (int i = 0; i < LANES; i++) begin
            op = d[i*DW +: DW];
            c  = ref_class(op);
            b.sign[i] = op[15];
            if (f && c == 3'd1) begin
                c  = 3'd0;
                op = {op[15], 15'd0};
            end
            b.cls[i*3 +: 3]   = c;
            b.data[i*DW +: DW] = op;
        end
        return b;
    endfunction

    function automatic int model_read(input logic [2:0] sel);
        return (sel < 3'd6) ? model_cnt[sel] : 0;
    endfunction

    // Monitor: scoreboard, stall stability and counter reference model.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            sb_q.delete();
            for (int c = 0; c < 6; c++) model_cnt[c] = 0;
            held = 1'b0;
        end else begin
            check_eq("cnt_value", 64'(cnt_value), 64'(model_read(cnt_sel)));
            if (held) begin
                check_eq("hold_data",  out_data,  held_beat.data);
                check_eq("hold_class", 64'(out_class), 64'(held_beat.cls));
                check_eq("hold_sign",  64'(out_sign),  64'(held_beat.sign));
            end
            held = out_valid & ~out_ready;
            held_beat.data = out_data;
            held_beat.cls  = out_class;
            held_beat.sign = out_sign;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("out_data",  out_data, e.data);
                    check_eq("out_class", 64'(out_class), 64'(e.cls));
                    check_eq("out_sign",  64'(out_sign),  64'(e.sign));
                    if (!cnt_clear) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (model_cnt[e.cls[l*3 +: 3]] < (1 << CW) - 1)
                                model_cnt[e.cls[l*3 +: 3]]++;
                        end
                    end
                end
            end
            if (cnt_clear) begin
                for (int c = 0; c < 6; c++) model_cnt[c] = 0;
            end
            if (in_valid && in_ready) sb_q.push_back(predict(in_data, ftz));
        end
    end

    task automatic send_beat(input logic [BW-1:0] d, input logic f);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        ftz      = f;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 50) begin
                    check_eq("send_timeout", 64'(n), 64'd0);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        cnt_clear = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
    endtask

    logic [BW-1:0] bp_data [5];
    initial begin
        bp_data[0] = {16'h4049, 16'hFF80, 16'h0040, 16'hC000};
        bp_data[1] = {16'h7FC1, 16'h8001, 16'h0000, 16'h3F80};
        bp_data[2] = {16'hFFA0, 16'h007F, 16'h7F80, 16'h8000};
        bp_data[3] = {16'h1234, 16'h8010, 16'hFFC0, 16'h7F7F};
        bp_data[4] = {16'h0001, 16'h0080, 16'h7F81, 16'hBF80};
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; ftz = 1'b0;
        out_ready = 1'b1; cnt_clear = 1'b0; cnt_sel = 3'd0;
        held = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data",  out_data, 64'd0);
        check_eq("rst_out_class", 64'(out_class), 64'd0);
        check_eq("rst_out_sign",  64'(out_sign), 64'd0);
        check_eq("rst_in_ready",  64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Single beat, ftz=0, 2-cycle latency
        send_beat({16'h0001, 16'h7F80, 16'h8000, 16'h3F80}, 1'b0);
        @(negedge clk);
        check_eq("lat_n1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_eq("lat_n2_valid", 64'(out_valid), 64'd1);
        check_eq("t1_class", 64'(out_class), 64'({3'd1, 3'd3, 3'd0, 3'd2}));
        check_eq("t1_sign",  64'(out_sign), 64'(4'b0010));
        check_eq("t1_data",  out_data, {16'h0001, 16'h7F80, 16'h8000, 16'h3F80});
        drain();

        // FTZ beat
        send_beat({16'h7F81, 16'h7FC0, 16'h8001, 16'h0001}, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_eq("ftz_valid", 64'(out_valid), 64'd1);
        check_eq("ftz_class", 64'(out_class), 64'({3'd5, 3'd4, 3'd0, 3'd0}));
        check_eq("ftz_data",  out_data, {16'h7F81, 16'h7FC0, 16'h8000, 16'h0000});
        check_eq("ftz_sign",  64'(out_sign), 64'(4'b0010));
        drain();

        // Backpressure: 5 beats, out_ready low for 3 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 5; i++) send_beat(bp_data[i], i[0]);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1 out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check_eq("bp_in_ready_full", 64'(in_ready), 64'd0);
                    check_eq("bp_out_valid", 64'(out_valid), 64'd1);
                    if (k < 2) begin
                        @(posedge clk);
                        #1;
                    end
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(negedge clk);
                check_eq("bp_in_ready_resume", 64'(in_ready), 64'd1);
            end
        join
        drain();

        // Counters: 3 all-NORM beats then 12; clear coinciding with 4th handshake
        clear_counters();
        cnt_sel = 3'd2;
        for (int i = 0; i < 3; i++) send_beat({4{16'h3F80}}, 1'b0);
        drain();
        @(negedge clk);
        check_eq("cnt_norm_12", 64'(cnt_value), 64'd12);
        @(posedge clk); #1;
        send_beat({4{16'h4000}}, 1'b0);
        @(posedge clk);
        #1 cnt_clear = 1'b1;
        @(negedge clk);
        check_eq("clr_coincide_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 cnt_clear = 1'b0;
        @(negedge clk);
        check_eq("clr_wins", 64'(cnt_value), 64'd0);
        cnt_sel = 3'd7;
        @(negedge clk);
        check_eq("cnt_sel7", 64'(cnt_value), 64'd0);
        @(posedge clk); #1;

        // Saturation: 5 all-zero beats into a 4-bit counter
        cnt_sel = 3'd0;
        for (int i = 0; i < 5; i++) send_beat({4{16'h0000}}, 1'b0);
        drain();
        @(negedge clk);
        check_eq("sat_15", 64'(cnt_value), 64'd15);
        @(posedge clk); #1;
        send_beat({16'h8000, 16'h0000, 16'h8000, 16'h0000}, 1'b0);
        drain();
        @(negedge clk);
        check_eq("sat_stays_15", 64'(cnt_value), 64'd15);
        @(posedge clk); #1;

        // Reset with both stages full
        out_ready = 1'b0;
        send_beat({4{16'h3F80}}, 1'b0);
        send_beat({4{16'h0001}}, 1'b1);
        @(negedge clk);
        check_eq("full_in_ready", 64'(in_ready), 64'd0);
        check_eq("full_out_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 64'(out_valid), 64'd0);
        check_eq("arst_cnt", 64'(cnt_value), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("post_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        send_beat({16'hFF80, 16'h7FC0, 16'h0010, 16'hBF80}, 1'b1);
        @(negedge clk);
        check_eq("post_rst_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_eq("post_rst_lat2", 64'(out_valid), 64'd1);
        drain();

        check_eq("sb_empty_end", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_fp_class_pipe
